uart_rx_axis: RTL and testbench



---
 rtl/uart_rx_axis.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_axis.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// UART receiver with an AXI4-Stream master output.
// Bit timing comes from an external baud tick. Each bit is sampled DELAY
// clocks after its tick. A good frame loads a single-entry output register.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_WAIT_IDLE | after reset; wait for a high sample before accepting starts
// S_IDLE      | line idle; a low sample is a start bit
// S_DATA      | shifting data bits, LSB first
// S_PARITY    | checking the parity bit against the received data
// S_STOP      | checking the stop bit(s); the frame completes on the last one
module uart_rx_axis #(
    parameter int PARITY_ENA  = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int DATA_BITS   = 8,
    parameter int DELAY       = 3,
    parameter int BUS_WIDTH   = 1
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   uart_ena,
    input  logic                   rxd,
    output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = 1'(PARITY_TYPE);

    logic strobe;

    generate
        if (DELAY == 0) begin : g_no_delay
            assign strobe = uart_ena;
        end else begin : g_delay
            localparam int CNT_W = $clog2(DELAY + 1);
            logic [CNT_W-1:0] dly_cnt;

            // Down-counter reloaded by every baud tick; terminal count 1 marks the sample cycle.
            always_ff @(posedge aclk or posedge arst) begin
                if (arst) begin
                    dly_cnt <= '0;
                end else if (uart_ena) begin
                    dly_cnt <= CNT_W'(DELAY);
                end else if (dly_cnt != '0) begin
                    dly_cnt <= dly_cnt - CNT_W'(1);
                end
            end

            assign strobe = (dly_cnt == CNT_W'(1)) && !uart_ena;
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   err_q, err_d;
    logic                   frame_ok;
    logic [BUS_WIDTH*8-1:0] tdata_d;
    logic                   tvalid_d;

    // Frame FSM: next state, bit counter, shift register and error flag.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_d     = err_q;
        frame_ok  = 1'b0;
        if (strobe) begin
            case (state_q)
                S_WAIT_IDLE: begin
                    if (rxd) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!rxd) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        err_d     = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d[bit_cnt_q] = rxd;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_ENA != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (((^shift_q) ^ rxd) != PAR_ODD) begin
                        err_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (!rxd) begin
                        err_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        frame_ok  = !err_q && rxd;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = S_WAIT_IDLE;
                end
            endcase
        end
    end

    // Output register: drain on handshake, load a good frame when there is room.
    always_comb begin
        tdata_d  = m_axis_tdata;
        tvalid_d = m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        if (frame_ok && (!m_axis_tvalid || m_axis_tready)) begin
            tdata_d                  = '0;
            tdata_d[DATA_BITS-1:0]   = shift_q;
            tvalid_d                 = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q       <= S_WAIT_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            err_q         <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            err_q         <= err_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: an 8N1 instance and an 8E1 instance share the clock,
// reset and baud tick. Frames are built bit by bit; the expected beats are
// kept in queues fed by a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_axis;

    logic       tb_data_clk   = 1'b0;
    logic       arst          = 1'b1;
    logic       uart_ena      = 1'b0;
    logic       rxd           = 1'b1;
    logic       rxd_p         = 1'b1;
    logic       m_axis_tready = 1'b1;
    logic       p_tready      = 1'b1;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic [7:0] p_tdata;
    logic       p_tvalid;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_p[$];
    bit         hold_full = 1'b0;

    uart_rx_axis #(
        .PARITY_ENA(0), .PARITY_TYPE(0), .STOP_BITS(1),
        .DATA_BITS(8), .DELAY(3), .BUS_WIDTH(1)
    ) dut (
        .aclk(tb_data_clk), .arst(arst), .uart_ena(uart_ena), .rxd(rxd),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    uart_rx_axis #(
        .PARITY_ENA(1), .PARITY_TYPE(0), .STOP_BITS(1),
        .DATA_BITS(8), .DELAY(3), .BUS_WIDTH(1)
    ) dut_par (
        .aclk(tb_data_clk), .arst(arst), .uart_ena(uart_ena), .rxd(rxd_p),
        .m_axis_tdata(p_tdata), .m_axis_tvalid(p_tvalid),
        .m_axis_tready(p_tready)
    );

    // 100 ns clock
    initial forever #50 tb_data_clk = ~tb_data_clk;

    // Free-running baud tick, one clock wide, every 10 clocks
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge tb_data_clk);
            uart_ena = (k == 0);
            k = (k == 9) ? 0 : k + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Change the line half a clock after the next baud tick edge
    task automatic send_bit(input logic b, input bit to_par);
        int n;
        n = 0;
        @(posedge tb_data_clk);
        while (!uart_ena && n < 20) begin
            @(posedge tb_data_clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL baud_tick_timeout waited=%0d cycles limit=20", n);
        end
        @(negedge tb_data_clk);
        if (to_par) rxd_p = b;
        else        rxd   = b;
    endtask

    task automatic send_frame(input logic [7:0] d, input int idle, input bit to_par,
                              input logic par_bit, input logic stop_val);
        repeat (idle) send_bit(1'b1, to_par);
        send_bit(1'b0, to_par);
        for (int i = 0; i < 8; i++) send_bit(d[i], to_par);
        if (to_par) send_bit(par_bit, to_par);
        send_bit(stop_val, to_par);
        if (!stop_val) send_bit(1'b1, to_par);
    endtask

    // Frame-level model of the 8N1 receiver: one holding slot, overruns dropped
    task automatic model_frame(input logic [7:0] d, input bit good);
        if (good) begin
            if (m_axis_tready) begin
                exp_q.push_back(d);
            end else if (!hold_full) begin
                exp_q.push_back(d);
                hold_full = 1'b1;
            end
        end
    endtask

    // Even parity: total number of ones in data plus parity bit is even
    function automatic bit even_par_ok(input logic [7:0] d, input logic p);
        return ((($countones(d) + int'(p)) % 2) == 0);
    endfunction

    // Beat monitors: a beat transfers on the next rising edge
    always @(negedge tb_data_clk) begin
        if (!arst && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("spurious_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
            else                   check("beat_data", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
        end
        if (!arst && p_tvalid && p_tready) begin
            if (exp_p.size() == 0) check("par_spurious_beat", 32'(p_tdata), 32'hFFFF_FFFF);
            else                   check("par_beat_data", 32'(p_tdata), 32'(exp_p.pop_front()));
        end
    end

    initial begin
        logic [7:0] d;
        logic       p;
        bit         bad;

        // Reset state
        repeat (2) @(posedge tb_data_clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("rst_tdata", 32'(m_axis_tdata), 32'h0);
        check("rst_par_tvalid", 32'(p_tvalid), 32'h0);
        @(negedge tb_data_clk);
        arst = 1'b0;

        // Basic receive with latency check
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hAA, 1, 1'b0, 1'b0, 1'b1);
            model_frame(8'hAA, 1'b1);
            if (i == 2) begin
                repeat (2) @(posedge tb_data_clk);
                #1;
                check("lat_before", 32'(m_axis_tvalid), 32'h0);
                @(posedge tb_data_clk);
                #1;
                check("lat_tvalid", 32'(m_axis_tvalid), 32'h1);
                check("lat_tdata", 32'(m_axis_tdata), 32'hAA);
            end
        end

        // Alternating stream, back to back
        for (int i = 0; i < 8; i++) begin
            d = (i % 2 == 0) ? 8'hAA : 8'h55;
            send_frame(d, 0, 1'b0, 1'b0, 1'b1);
            model_frame(d, 1'b1);
        end

        // Randomized frames with occasional framing errors and idle gaps
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, $urandom_range(0, 2), 1'b0, 1'b0, !bad);
            model_frame(d, !bad);
        end
        send_bit(1'b1, 1'b0);
        check("rand_drained", 32'(exp_q.size()), 32'h0);

        // Backpressure: second frame overruns and is dropped
        @(posedge tb_data_clk);
        #1;
        m_axis_tready = 1'b0;
        hold_full = 1'b0;
        send_frame(8'hAA, 1, 1'b0, 1'b0, 1'b1);
        model_frame(8'hAA, 1'b1);
        send_frame(8'h55, 0, 1'b0, 1'b0, 1'b1);
        model_frame(8'h55, 1'b1);
        repeat (5) @(posedge tb_data_clk);
        #1;
        check("bp_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("bp_tdata", 32'(m_axis_tdata), 32'hAA);
        @(posedge tb_data_clk);
        #1;
        m_axis_tready = 1'b1;
        hold_full = 1'b0;
        repeat (2) send_bit(1'b1, 1'b0);
        check("bp_drained", 32'(exp_q.size()), 32'h0);
        check("bp_tvalid_low", 32'(m_axis_tvalid), 32'h0);

        // Framing error then good frame
        send_frame(8'h3C, 1, 1'b0, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0);
        send_frame(8'h81, 1, 1'b0, 1'b0, 1'b1);
        model_frame(8'h81, 1'b1);
        repeat (2) send_bit(1'b1, 1'b0);
        check("frm_drained", 32'(exp_q.size()), 32'h0);

        // Parity instance: directed then randomized
        send_frame(8'h07, 1, 1'b1, 1'b1, 1'b1);
        if (even_par_ok(8'h07, 1'b1)) exp_p.push_back(8'h07);
        send_frame(8'h07, 1, 1'b1, 1'b0, 1'b1);
        if (even_par_ok(8'h07, 1'b0)) exp_p.push_back(8'h07);
        repeat (2) send_bit(1'b1, 1'b1);
        check("par_directed", 32'(exp_p.size()), 32'h0);
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            send_frame(d, $urandom_range(0, 1), 1'b1, p, 1'b1);
            if (even_par_ok(d, p)) exp_p.push_back(d);
        end
        repeat (2) send_bit(1'b1, 1'b1);
        check("par_drained", 32'(exp_p.size()), 32'h0);

        // Reset in the middle of the data bits of 0xAA
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        #10;
        arst = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("mid_rst_tdata", 32'(m_axis_tdata), 32'h0);
        rxd = 1'b1;
        repeat (2) @(posedge tb_data_clk);
        @(negedge tb_data_clk);
        arst = 1'b0;
        send_frame(8'h55, 2, 1'b0, 1'b0, 1'b1);
        model_frame(8'h55, 1'b1);

        repeat (3) send_bit(1'b1, 1'b0);
        check("final_drained", 32'(exp_q.size()), 32'h0);
        check("final_par_drained", 32'(exp_p.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
